// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one spi_tx serialiser between NREQ requesters.
// Latches word/width/divider at grant, forces an idle gap after each transfer and aborts hung transfers.
module spi_tx_arbiter #(
    parameter int NREQ           = 3,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*32-1:0]      req_data,
    input  logic [NREQ*5-1:0]       req_width,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_done,
    input  logic [15:0]             bit_period_cfg,
    output logic                    spi_start,
    output logic [31:0]             spi_data,
    output logic [4:0]              spi_width,
    output logic [15:0]             spi_bit_period,
    input  logic                    spi_busy,
    input  logic                    spi_done,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    active,
    output logic                    timeout_err,
    input  logic                    err_clear
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   rrPtr_q, rrPtr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            active_q, active_d;
    logic [NREQ-1:0] reqReady_q, reqReady_d;
    logic [NREQ-1:0] reqDone_q, reqDone_d;
    logic            spiStart_q, spiStart_d;
    logic [31:0]     spiData_q, spiData_d;
    logic [4:0]      spiWidth_q, spiWidth_d;
    logic [15:0]     spiBitPeriod_q, spiBitPeriod_d;
    logic            timeoutErr_q, timeoutErr_d;
    logic [31:0]     toCnt_q, toCnt_d;
    logic [31:0]     gapCnt_q, gapCnt_d;

    logic [OW-1:0]   winner;
    logic            found;
    int              idx;

    // First asserted request at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                winner = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= IDLE;
            rrPtr_q        <= '0;
            owner_q        <= '0;
            active_q       <= 1'b0;
            reqReady_q     <= '0;
            reqDone_q      <= '0;
            spiStart_q     <= 1'b0;
            spiData_q      <= '0;
            spiWidth_q     <= '0;
            spiBitPeriod_q <= '0;
            timeoutErr_q   <= 1'b0;
            toCnt_q        <= '0;
            gapCnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            rrPtr_q        <= rrPtr_d;
            owner_q        <= owner_d;
            active_q       <= active_d;
            reqReady_q     <= reqReady_d;
            reqDone_q      <= reqDone_d;
            spiStart_q     <= spiStart_d;
            spiData_q      <= spiData_d;
            spiWidth_q     <= spiWidth_d;
            spiBitPeriod_q <= spiBitPeriod_d;
            timeoutErr_q   <= timeoutErr_d;
            toCnt_q        <= toCnt_d;
            gapCnt_q       <= gapCnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rrPtr_d        = rrPtr_q;
        owner_d        = owner_q;
        active_d       = active_q;
        reqReady_d     = '0;
        reqDone_d      = '0;
        spiStart_d     = 1'b0;
        spiData_d      = spiData_q;
        spiWidth_d     = spiWidth_q;
        spiBitPeriod_d = spiBitPeriod_q;
        timeoutErr_d   = timeoutErr_q;
        toCnt_d        = toCnt_q;
        gapCnt_d       = gapCnt_q;

        // A timeout later in this block overrides the clear.
        if (err_clear) timeoutErr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found && !spi_busy) begin
                    spiData_d      = req_data[32*winner +: 32];
                    spiWidth_d     = req_width[5*winner +: 5];
                    spiBitPeriod_d = bit_period_cfg;
                    owner_d        = winner;
                    reqReady_d     = NREQ'(1) << winner;
                    spiStart_d     = 1'b1;
                    active_d       = 1'b1;
                    rrPtr_d        = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    toCnt_d        = '0;
                    state_d        = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                toCnt_d = toCnt_q + 32'd1;
                if (spi_done || (TIMEOUT_CYCLES != 0 && toCnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    if (!spi_done) timeoutErr_d = 1'b1;
                    reqDone_d = NREQ'(1) << owner_q;
                    active_d  = 1'b0;
                    gapCnt_d  = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gapCnt_q == 32'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready      = reqReady_q;
    assign req_done       = reqDone_q;
    assign spi_start      = spiStart_q;
    assign spi_data       = spiData_q;
    assign spi_width      = spiWidth_q;
    assign spi_bit_period = spiBitPeriod_q;
    assign owner          = owner_q;
    assign active         = active_q;
    assign timeout_err    = timeoutErr_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter (NREQ=3, GAP_CYCLES=4, TIMEOUT_CYCLES=50); the bench plays spi_tx.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_spi_tx_arbiter;

    localparam int NREQ = 3;
    localparam int GAP  = 4;
    localparam int TMO  = 50;

    logic              clk = 1'b0;
    logic              nrst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*5-1:0] req_width;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_done;
    logic [15:0]       bit_period_cfg;
    logic              spi_start;
    logic [31:0]       spi_data;
    logic [4:0]        spi_width;
    logic [15:0]       spi_bit_period;
    logic              spi_busy;
    logic              spi_done;
    logic [1:0]        owner;
    logic              active;
    logic              timeout_err;
    logic              err_clear;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] expData [NREQ];
    logic [4:0]  expWidth [NREQ];

    spi_tx_arbiter #(
        .NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_data(req_data), .req_width(req_width),
        .req_ready(req_ready), .req_done(req_done),
        .bit_period_cfg(bit_period_cfg),
        .spi_start(spi_start), .spi_data(spi_data), .spi_width(spi_width),
        .spi_bit_period(spi_bit_period), .spi_busy(spi_busy), .spi_done(spi_done),
        .owner(owner), .active(active), .timeout_err(timeout_err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid);
        req_valid = valid;
        tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 0);
        checkOutput({tag, " req_done"}, 32'(req_done), 0);
        checkOutput({tag, " spi_start"}, 32'(spi_start), 0);
        checkOutput({tag, " spi_data"}, spi_data, 0);
        checkOutput({tag, " spi_width"}, 32'(spi_width), 0);
        checkOutput({tag, " spi_bit_period"}, 32'(spi_bit_period), 0);
        checkOutput({tag, " owner"}, 32'(owner), 0);
        checkOutput({tag, " active"}, 32'(active), 0);
        checkOutput({tag, " timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Waits (bounded) for a grant, checks it, then completes the transfer with a spi_done pulse.
    task automatic runTransfer(input int expOwner, input string tag);
        int n = 0;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, " grant seen"}, 32'(req_ready != '0), 1);
        checkOutput({tag, " owner"}, 32'(owner), 32'(expOwner));
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(1 << expOwner));
        checkOutput({tag, " spi_data"}, spi_data, expData[expOwner]);
        req_valid[expOwner] = 1'b0;
        tick();
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checkOutput({tag, " req_done"}, 32'(req_done), 32'(1 << expOwner));
        checkOutput({tag, " active"}, 32'(active), 0);
    endtask

    initial begin
        int n;
        int grants;
        expData[0] = 32'hDEAD_0000; expWidth[0] = 5'd31;
        expData[1] = 32'h0000_00A5; expWidth[1] = 5'd7;
        expData[2] = 32'hC0DE_0002; expWidth[2] = 5'd15;
        req_data  = {expData[2], expData[1], expData[0]};
        req_width = {expWidth[2], expWidth[1], expWidth[0]};
        nrst = 1'b0; req_valid = '0; spi_busy = 1'b0; spi_done = 1'b0;
        err_clear = 1'b0; bit_period_cfg = 16'd4;
        repeat (3) tick();
        checkResetOutputs("reset");
        nrst = 1'b1;
        tick();

        // Single request from requester 1, valid held one cycle past req_ready.
        applyStimulus(3'b010);
        checkOutput("single req_ready", 32'(req_ready), 32'b010);
        checkOutput("single spi_start", 32'(spi_start), 1);
        checkOutput("single spi_data", spi_data, 32'hA5);
        checkOutput("single spi_width", 32'(spi_width), 7);
        checkOutput("single spi_bit_period", 32'(spi_bit_period), 4);
        checkOutput("single owner", 32'(owner), 1);
        checkOutput("single active", 32'(active), 1);
        tick();
        checkOutput("single ready pulse", 32'(req_ready), 0);
        checkOutput("single start pulse", 32'(spi_start), 0);
        checkOutput("single still active", 32'(active), 1);
        req_valid = '0;
        bit_period_cfg = 16'd9;
        tick();
        checkOutput("cfg held mid-transfer", 32'(spi_bit_period), 4);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checkOutput("single req_done", 32'(req_done), 32'b010);
        checkOutput("single inactive", 32'(active), 0);

        // Request during GAP: spi_start lands GAP+1 edges after req_done.
        req_valid = 3'b100;
        n = 0;
        while (!spi_start && n < 20) begin
            tick();
            n++;
        end
        checkOutput("gap cycles to start", 32'(n), 32'(GAP + 1));
        checkOutput("gap owner", 32'(owner), 2);
        checkOutput("cfg latched at grant", 32'(spi_bit_period), 9);
        req_valid = '0;

        // No spi_done: timeout fires TMO cycles after spi_start.
        n = 0;
        while (req_done == '0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("timeout cycles", 32'(n), 32'(TMO));
        checkOutput("timeout req_done", 32'(req_done), 32'b100);
        checkOutput("timeout_err set", 32'(timeout_err), 1);
        checkOutput("timeout inactive", 32'(active), 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutput("timeout_err cleared", 32'(timeout_err), 0);

        // spi_busy blocks grants until it drops.
        spi_busy = 1'b1;
        req_valid = 3'b001;
        grants = 0;
        repeat (12) begin
            tick();
            if (req_ready != '0) grants++;
        end
        checkOutput("busy blocks grant", 32'(grants), 0);
        spi_busy = 1'b0;
        tick();
        checkOutput("busy drop grant", 32'(req_ready), 32'b001);
        checkOutput("busy drop data", spi_data, 32'hDEAD_0000);
        checkOutput("busy drop width", 32'(spi_width), 31);
        req_valid = '0;
        tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checkOutput("busy xfer req_done", 32'(req_done), 32'b001);
        repeat (6) tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        checkOutput("spurious done ignored", 32'(req_done), 0);
        checkOutput("spurious no active", 32'(active), 0);

        // Round robin from reset with all requests pending.
        nrst = 1'b0;
        req_valid = 3'b111;
        tick();
        tick();
        nrst = 1'b1;
        runTransfer(0, "rr first");
        runTransfer(1, "rr second");
        runTransfer(2, "rr third");
        req_valid = 3'b101;
        runTransfer(0, "rr fourth");
        runTransfer(2, "rr fifth");

        // Reset during WAIT_DONE with rr pointer at 2; requester 0 must win afterwards.
        repeat (6) tick();
        applyStimulus(3'b010);
        checkOutput("pre-reset grant", 32'(req_ready), 32'b010);
        req_valid = '0;
        tick();
        nrst = 1'b0;
        tick();
        checkResetOutputs("mid reset");
        req_valid = 3'b111;
        nrst = 1'b1;
        tick();
        checkOutput("post-reset ready", 32'(req_ready), 32'b001);
        checkOutput("post-reset owner", 32'(owner), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
